mem_stage_unit: RTL and testbench
=================================

MEM_STAGE_UNIT -- requirements
Module: mem_stage_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 inst_from_execute_stage  input  32  instruction in mem stage; funct3 = bits[14:12].
REQ-004 alu_result_from_execute_stage  input  32  result for non-load writeback.
REQ-005 rd_index_from_execute_stage  input  5  destination register index.
REQ-006 mem_read_signal_from_execute_stage  input  1  load present.
REQ-007 mem_write_signal_from_execute_stage  input  1  store present.
REQ-008 regfile_write_signal_from_execute_stage  input  1  instruction writes rd.
REQ-009 mem_read_address_from_execute_stage  input  32  load byte address.
REQ-010 mem_write_address_from_execute_stage  input  32  store byte address.
REQ-011 rs2_reg_content_from_execute_stage  input  32  store data, unaligned (low bytes valid).
REQ-012 dmem_ready  input  1  memory accepts request this cycle.
REQ-013 dmem_rvalid  input  1  load data valid this cycle.
REQ-014 dmem_rdata  input  32  load word.
REQ-015 dmem_req  output  1  request valid.
REQ-016 dmem_we  output  1  1 = write, 0 = read.
REQ-017 dmem_addr  output  32  word address, bits[1:0] = 0.
REQ-018 dmem_wdata  output  32  lane-shifted store data.
REQ-019 dmem_be  output  4  byte enables; 4'b0000 on reads.
REQ-020 stall_mem_stage  output  1  freeze IF/ID/EX; upstream holds inputs stable while high.
REQ-021 inst_for_writeback_stage  output  32  registered instruction.
REQ-022 rd_reg_content_for_writeback_stage  output  32  registered write data.
REQ-023 rd_index_for_writeback_stage  output  5  registered rd.
REQ-024 regfile_write_signal_for_writeback_stage  output  1  registered write enable.
REQ-025 misaligned_access_signal  output  1  registered one-cycle flag, misaligned access dropped.

Function
REQ-026 FSM states IDLE, REQ, WAIT_RESP; mem op = read|write signal and not misaligned.
REQ-027 In IDLE or REQ with mem op, dmem_req is driven combinationally that cycle.
- IDLE->REQ if !dmem_ready; stay in REQ until dmem_ready.
REQ-028 On accept of a load: ->WAIT_RESP; stay until dmem_rvalid, then ->IDLE.
- Accept of a store: completion that cycle, ->IDLE.
- dmem_rvalid never arrives earlier than one cycle after accept.
REQ-029 stall_mem_stage = mem op && !completion this cycle.
- Completion = store accept, or dmem_rvalid in WAIT_RESP.
- stall_mem_stage is 0 for non-memory instructions.
REQ-030 Writeback registers update every cycle.
- Stalled cycle: bubble (`NOP_INSTRUCTION, regfile_write 0, rd 0, data 0).
- Otherwise: instruction fields with one-cycle latency.
REQ-031 Write data: load completion -> extracted rdata; else alu_result.
REQ-032 Load funct3 000/001/010/100/101 = LB/LH/LW/LBU/LHU.
- Lane selected by addr[1:0]; sign-extend (LB, LH) or zero-extend (LBU, LHU).
REQ-033 Store funct3 000/001/010 = SB/SH/SW.
- be = 0001<<a[1:0] / 0011<<a[1:0] / 1111.
- wdata = rs2 replicated to all lanes (byte x4, half x2).
REQ-034 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- No dmem_req, no stall; writeback is a bubble with misaligned_access_signal=1 for one cycle.
REQ-035 dmem_addr, dmem_we, dmem_be and dmem_wdata hold stable while dmem_req=1 and dmem_ready=0.
REQ-036 dmem_rvalid outside WAIT_RESP is ignored.

Reset
REQ-037 On rst: FSM->IDLE; all writeback outputs 0 except inst=`NOP_INSTRUCTION; misaligned 0.
- In-flight transaction abandoned; dmem_req 0 in the cycle after the reset edge unless a new op is present.

Structure
REQ-038 common.vh holds the load/store funct3 codes, FSM state encodings and `NOP_INSTRUCTION, alongside the existing opcode defines.
REQ-039 One combinational sub-module, load_store_aligner, holds lane shift, byte enables, extraction, extension and the misalignment check.

Verification
REQ-040 ADD result 0x12345678, no mem op -> next cycle rd_reg_content=0x12345678, regfile_write=1, stall 0.
REQ-041 LB, addr 0x103, ready=1, rvalid one cycle later with rdata 0x80FF_0000.
- stall high 2 cycles; dmem_addr 0x100; writeback 0xFFFFFF80.
REQ-042 SH, addr 0x202, rs2 0xAAAA1234, ready low 3 cycles.
- stall high 3 cycles; req held with be=1100, wdata=0x12341234; completes on 4th cycle.
REQ-043 LW, addr 0x101 -> no dmem_req, no stall; misaligned=1 one cycle; regfile_write 0.
REQ-044 rst asserted in WAIT_RESP, then rvalid arrives -> data ignored, outputs at reset values, FSM IDLE.
REQ-045 LHU, addr 0x2, rdata 0xBEEF0000 -> writeback 0x0000BEEF.

Source files
------------

// File: rtl/mem_stage_unit_pkg.sv
// rtl/mem_stage_unit_pkg.sv - shared defines and types for the memory stage
// Opcode, load/store funct3 and FSM encodings, plus the memory-stage state type.
`ifndef COMMON_VH
`define COMMON_VH

`define OPCODE_LOAD        7'b0000011
`define OPCODE_STORE       7'b0100011
`define OPCODE_OP          7'b0110011
`define OPCODE_OP_IMM      7'b0010011

// addi x0, x0, 0
`define NOP_INSTRUCTION    32'h00000013

`define FUNCT3_LB          3'b000
`define FUNCT3_LH          3'b001
`define FUNCT3_LW          3'b010
`define FUNCT3_LBU         3'b100
`define FUNCT3_LHU         3'b101
`define FUNCT3_SB          3'b000
`define FUNCT3_SH          3'b001
`define FUNCT3_SW          3'b010

`define MEM_STATE_IDLE      2'd0
`define MEM_STATE_REQ       2'd1
`define MEM_STATE_WAIT_RESP 2'd2

`endif

package mem_stage_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = `MEM_STATE_IDLE,
        ST_REQ       = `MEM_STATE_REQ,
        ST_WAIT_RESP = `MEM_STATE_WAIT_RESP
    } mem_state_t;

endpackage

// File: rtl/mem_stage_unit_aligner.sv
// rtl/mem_stage_unit_aligner.sv - combinational load/store lane alignment
// Inputs : funct3, is_load, is_store, byte_offset (addr[1:0]), store_data (rs2),
//          load_word (dmem_rdata)
// Outputs: misaligned, byte_enable, store_lanes, load_value
module load_store_aligner (
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        misaligned,
    output logic [3:0]  byte_enable,
    output logic [31:0] store_lanes,
    output logic [31:0] load_value
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        misaligned = 1'b0;
        if (is_load) begin
            case (funct3)
                `FUNCT3_LH, `FUNCT3_LHU: misaligned = byte_offset[0];
                `FUNCT3_LW:              misaligned = (byte_offset != 2'b00);
                default:                 misaligned = 1'b0;
            endcase
        end else if (is_store) begin
            case (funct3)
                `FUNCT3_SH: misaligned = byte_offset[0];
                `FUNCT3_SW: misaligned = (byte_offset != 2'b00);
                default:    misaligned = 1'b0;
            endcase
        end
    end

    // Stores replicate the datum across every lane; byte enables pick the real one.
    always_comb begin
        byte_enable = 4'b0000;
        store_lanes = store_data;
        case (funct3)
            `FUNCT3_SB: begin
                byte_enable = 4'b0001 << byte_offset;
                store_lanes = {4{store_data[7:0]}};
            end
            `FUNCT3_SH: begin
                byte_enable = 4'b0011 << byte_offset;
                store_lanes = {2{store_data[15:0]}};
            end
            default: begin
                byte_enable = 4'b1111;
                store_lanes = store_data;
            end
        endcase
        if (!is_store) begin
            byte_enable = 4'b0000;
        end
    end

    always_comb begin
        case (byte_offset)
            2'd0:    lane_byte = load_word[7:0];
            2'd1:    lane_byte = load_word[15:8];
            2'd2:    lane_byte = load_word[23:16];
            default: lane_byte = load_word[31:24];
        endcase
        lane_half = byte_offset[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            `FUNCT3_LB:  load_value = {{24{lane_byte[7]}}, lane_byte};
            `FUNCT3_LH:  load_value = {{16{lane_half[15]}}, lane_half};
            `FUNCT3_LBU: load_value = {24'd0, lane_byte};
            `FUNCT3_LHU: load_value = {16'd0, lane_half};
            default:     load_value = load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - pipeline memory stage with handshaked data memory port
// Inputs : clk, rst, execute-stage instruction fields, dmem_ready/rvalid/rdata
// Outputs: dmem_req/we/addr/wdata/be, stall_mem_stage, registered writeback fields,
//          misaligned_access_signal
module mem_stage_unit
    import mem_stage_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_from_execute_stage,
    input  logic [31:0] alu_result_from_execute_stage,
    input  logic [4:0]  rd_index_from_execute_stage,
    input  logic        mem_read_signal_from_execute_stage,
    input  logic        mem_write_signal_from_execute_stage,
    input  logic        regfile_write_signal_from_execute_stage,
    input  logic [31:0] mem_read_address_from_execute_stage,
    input  logic [31:0] mem_write_address_from_execute_stage,
    input  logic [31:0] rs2_reg_content_from_execute_stage,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_mem_stage,
    output logic [31:0] inst_for_writeback_stage,
    output logic [31:0] rd_reg_content_for_writeback_stage,
    output logic [4:0]  rd_index_for_writeback_stage,
    output logic        regfile_write_signal_for_writeback_stage,
    output logic        misaligned_access_signal
);

    mem_state_t  state_q, state_d;
    logic        is_load, is_store, mem_op, misaligned, completion, load_done;
    logic [31:0] access_addr, load_value;

    assign is_load     = mem_read_signal_from_execute_stage;
    assign is_store    = mem_write_signal_from_execute_stage && !is_load;
    assign access_addr = is_load ? mem_read_address_from_execute_stage
                                 : mem_write_address_from_execute_stage;

    load_store_aligner u_aligner (
        .funct3      (inst_from_execute_stage[14:12]),
        .is_load     (is_load),
        .is_store    (is_store),
        .byte_offset (access_addr[1:0]),
        .store_data  (rs2_reg_content_from_execute_stage),
        .load_word   (dmem_rdata),
        .misaligned  (misaligned),
        .byte_enable (dmem_be),
        .store_lanes (dmem_wdata),
        .load_value  (load_value)
    );

    // Request fields are pure functions of the held upstream inputs, so they stay
    // stable for as long as the stall keeps the execute stage frozen.
    assign mem_op    = (is_load || is_store) && !misaligned;
    assign dmem_we   = is_store;
    assign dmem_addr = {access_addr[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        dmem_req   = 1'b0;
        completion = 1'b0;
        case (state_q)
            ST_IDLE, ST_REQ: begin
                if (mem_op) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        if (is_load) begin
                            state_d = ST_WAIT_RESP;
                        end else begin
                            completion = 1'b1;
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RESP: begin
                // rvalid only counts here; stray beats in other states are dropped.
                if (dmem_rvalid) begin
                    completion = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_done       = (state_q == ST_WAIT_RESP) && dmem_rvalid;
    assign stall_mem_stage = mem_op && !completion;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                                  <= ST_IDLE;
            inst_for_writeback_stage                 <= `NOP_INSTRUCTION;
            rd_reg_content_for_writeback_stage       <= 32'd0;
            rd_index_for_writeback_stage             <= 5'd0;
            regfile_write_signal_for_writeback_stage <= 1'b0;
            misaligned_access_signal                 <= 1'b0;
        end else begin
            state_q                  <= state_d;
            misaligned_access_signal <= misaligned;
            // A dropped misaligned access and a stalled cycle both send a bubble.
            if (stall_mem_stage || misaligned) begin
                inst_for_writeback_stage                 <= `NOP_INSTRUCTION;
                rd_reg_content_for_writeback_stage       <= 32'd0;
                rd_index_for_writeback_stage             <= 5'd0;
                regfile_write_signal_for_writeback_stage <= 1'b0;
            end else begin
                inst_for_writeback_stage                 <= inst_from_execute_stage;
                rd_reg_content_for_writeback_stage       <= load_done ? load_value
                                                                      : alu_result_from_execute_stage;
                rd_index_for_writeback_stage             <= rd_index_from_execute_stage;
                regfile_write_signal_for_writeback_stage <= regfile_write_signal_from_execute_stage;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst, alu, raddr, waddr, rs2, rdata;
    logic [4:0]  rd;
    logic        mr, mw, wb, ready, rvalid;
    logic        dmem_req, dmem_we, stall, wb_wr, mis_flag;
    logic [31:0] dmem_addr, dmem_wdata, wb_inst, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    mem_stage_unit u_dut (
        .clk                                      (clk),
        .rst                                      (rst),
        .inst_from_execute_stage                  (inst),
        .alu_result_from_execute_stage            (alu),
        .rd_index_from_execute_stage              (rd),
        .mem_read_signal_from_execute_stage       (mr),
        .mem_write_signal_from_execute_stage      (mw),
        .regfile_write_signal_from_execute_stage  (wb),
        .mem_read_address_from_execute_stage      (raddr),
        .mem_write_address_from_execute_stage     (waddr),
        .rs2_reg_content_from_execute_stage       (rs2),
        .dmem_ready                               (ready),
        .dmem_rvalid                              (rvalid),
        .dmem_rdata                               (rdata),
        .dmem_req                                 (dmem_req),
        .dmem_we                                  (dmem_we),
        .dmem_addr                                (dmem_addr),
        .dmem_wdata                               (dmem_wdata),
        .dmem_be                                  (dmem_be),
        .stall_mem_stage                          (stall),
        .inst_for_writeback_stage                 (wb_inst),
        .rd_reg_content_for_writeback_stage       (wb_data),
        .rd_index_for_writeback_stage             (wb_rd),
        .regfile_write_signal_for_writeback_stage (wb_wr),
        .misaligned_access_signal                 (mis_flag)
    );

    int checks = 0;
    int failures = 0;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference rules: access width/alignment, lane data by shifting, replication by multiply.
    function automatic logic mdl_mis(input logic [2:0] f, input logic [1:0] a);
        if (f == 3'd1 || f == 3'd5) return a[0];
        if (f == 3'd2) return a != 2'd0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w;
        if (f == 3'd0 || f == 3'd4) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (f == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
        end else if (f == 3'd1 || f == 3'd5) begin
            v = (w >> (8 * a)) & 32'hFFFF;
            if (f == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] mdl_be(input logic [2:0] f, input logic [1:0] a);
        if (f == 3'd0) return 4'b0001 << a;
        if (f == 3'd1) return 4'b0011 << a;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'd0) return (d & 32'hFF) * 32'h01010101;
        if (f == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // Transaction-level model: an op is "accepted" once a load handshake happened,
    // writeback expectations are produced one cycle ahead of the compare.
    logic        m_live = 1'b0, m_known = 1'b0, m_acc = 1'b0;
    logic [31:0] e_inst, e_data;
    logic [4:0]  e_rd;
    logic        e_wr, e_mis;

    always @(negedge clk) begin
        logic [2:0]  f;
        logic [31:0] a;
        logic        mis, op, req, comp, stl, st;
        f    = inst[14:12];
        a    = mr ? raddr : waddr;
        st   = mw && !mr;
        mis  = (mr || mw) && mdl_mis(f, a[1:0]);
        op   = (mr || mw) && !mis;
        req  = op && !m_acc;
        comp = (st && req && ready) || (mr && op && m_acc && rvalid);
        stl  = op && !comp;
        if (m_live) begin
            chk("model_req", dmem_req, req);
            chk("model_stall", stall, stl);
            if (req) begin
                chk("model_addr", dmem_addr, a & 32'hFFFFFFFC);
                chk("model_we", dmem_we, st);
                chk("model_be", dmem_be, st ? mdl_be(f, a[1:0]) : 4'b0000);
                if (st) chk("model_wdata", dmem_wdata, mdl_wdata(f, rs2));
            end
            if (m_known) begin
                chk("model_wb_inst", wb_inst, e_inst);
                chk("model_wb_data", wb_data, e_data);
                chk("model_wb_rd", wb_rd, e_rd);
                chk("model_wb_wr", wb_wr, e_wr);
                chk("model_mis", mis_flag, e_mis);
            end
        end
        if (rst || mis || stl) begin
            e_inst = 32'h00000013; e_data = 32'd0; e_rd = 5'd0; e_wr = 1'b0;
            e_mis  = !rst && mis;
        end else begin
            e_inst = inst; e_rd = rd; e_wr = wb; e_mis = 1'b0;
            e_data = (mr && comp) ? mdl_load(f, a[1:0], rdata) : alu;
        end
        if (rst) m_acc = 1'b0;
        else if (mr && req && ready) m_acc = 1'b1;
        else if (comp) m_acc = 1'b0;
        if (rst) m_live = 1'b1;
        m_known = 1'b1;
    end

    always @(negedge clk) begin
        if (stall === 1'b1) stall_cnt++;
    end

    typedef struct {
        logic        ld;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] val;
        int          rdy_wait;
        int          rv_wait;
        logic [31:0] exp;
        logic [3:0]  be;
        int          exp_stall;
        logic        mis;
    } op_t;

    op_t ops [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst = 32'h00000013; alu = 32'd0; rd = 5'd0; mr = 1'b0; mw = 1'b0; wb = 1'b0;
        raddr = 32'd0; waddr = 32'd0; rs2 = 32'd0; ready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    endtask

    task automatic drive_op(input op_t o, input int idx);
        inst  = {17'd0, o.f3, 5'd5, o.ld ? 7'h03 : 7'h23};
        alu   = 32'h5A5A0000 + idx;
        rd    = 5'd5;
        mr    = o.ld;
        mw    = !o.ld;
        wb    = o.ld;
        raddr = o.ld ? o.addr : 32'h00000F0F;
        waddr = o.ld ? 32'h00000E0E : o.addr;
        rs2   = o.ld ? 32'h0BADF00D : o.val;
        rdata = ~o.val;
        rvalid = 1'b0;
    endtask

    task automatic run_op(input op_t o, input int idx);
        step();
        stall_cnt = 0;
        drive_op(o, idx);
        ready = (o.rdy_wait == 0);
        if (!o.ld && !o.mis) begin
            @(negedge clk);
            chk($sformatf("op%0d_be", idx), dmem_be, o.be);
            chk($sformatf("op%0d_wdata", idx), dmem_wdata, o.exp);
        end
        for (int c = 0; c < o.rdy_wait; c++) begin
            step();
            if (c == o.rdy_wait - 1) ready = 1'b1;
        end
        step();
        ready = 1'b0;
        if (o.ld && !o.mis) begin
            repeat (o.rv_wait) step();
            rvalid = 1'b1;
            rdata  = o.val;
            step();
        end
        idle();
        @(negedge clk);
        chk($sformatf("op%0d_stall_cycles", idx), stall_cnt, o.exp_stall);
        if (o.mis) begin
            chk($sformatf("op%0d_mis", idx), mis_flag, 1'b1);
            chk($sformatf("op%0d_wr", idx), wb_wr, 1'b0);
        end else if (o.ld) begin
            chk($sformatf("op%0d_data", idx), wb_data, o.exp);
            chk($sformatf("op%0d_wr", idx), wb_wr, 1'b1);
        end
    endtask

    initial begin
        ops[0]  = '{1'b1, 3'd0, 32'h103, 32'h80FF0000, 0, 1, 32'hFFFFFF80, 4'h0, 2, 1'b0};
        ops[1]  = '{1'b0, 3'd1, 32'h202, 32'hAAAA1234, 3, 0, 32'h12341234, 4'hC, 3, 1'b0};
        ops[2]  = '{1'b1, 3'd2, 32'h101, 32'h11111111, 0, 0, 32'h0,        4'h0, 0, 1'b1};
        ops[3]  = '{1'b1, 3'd5, 32'h002, 32'hBEEF0000, 0, 0, 32'h0000BEEF, 4'h0, 1, 1'b0};
        ops[4]  = '{1'b1, 3'd4, 32'h101, 32'h0012AB00, 1, 0, 32'h000000AB, 4'h0, 2, 1'b0};
        ops[5]  = '{1'b1, 3'd1, 32'h006, 32'h80010000, 2, 1, 32'hFFFF8001, 4'h0, 4, 1'b0};
        ops[6]  = '{1'b1, 3'd2, 32'h104, 32'hCAFEF00D, 1, 3, 32'hCAFEF00D, 4'h0, 5, 1'b0};
        ops[7]  = '{1'b1, 3'd0, 32'h000, 32'h0000007F, 0, 0, 32'h0000007F, 4'h0, 1, 1'b0};
        ops[8]  = '{1'b0, 3'd0, 32'h203, 32'h000000A5, 0, 0, 32'hA5A5A5A5, 4'h8, 0, 1'b0};
        ops[9]  = '{1'b0, 3'd2, 32'h208, 32'h11223344, 2, 0, 32'h11223344, 4'hF, 2, 1'b0};
        ops[10] = '{1'b0, 3'd2, 32'h20A, 32'h55667788, 0, 0, 32'h0,        4'h0, 0, 1'b1};
        ops[11] = '{1'b0, 3'd1, 32'h201, 32'h99998888, 0, 0, 32'h0,        4'h0, 0, 1'b1};
        ops[12] = '{1'b1, 3'd1, 32'h002, 32'h7FFF0000, 0, 0, 32'h00007FFF, 4'h0, 1, 1'b0};

        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_inst", wb_inst, 32'h00000013);
        chk("reset_data", wb_data, 32'd0);
        chk("reset_rd", wb_rd, 5'd0);
        chk("reset_wr", wb_wr, 1'b0);
        chk("reset_mis", mis_flag, 1'b0);
        chk("reset_req", dmem_req, 1'b0);

        // ADD with a stray rvalid beat that must be ignored
        step();
        inst = {7'd0, 5'd2, 5'd1, 3'b000, 5'd10, 7'h33};
        alu = 32'h12345678; rd = 5'd10; wb = 1'b1;
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("add_stall", stall, 1'b0);
        chk("add_req", dmem_req, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("add_data", wb_data, 32'h12345678);
        chk("add_wr", wb_wr, 1'b1);
        chk("add_rd", wb_rd, 5'd10);

        for (int i = 0; i < 13; i++) run_op(ops[i], i);

        // Reset while a load waits for its data; the late beat is discarded
        step();
        drive_op('{1'b1, 3'd2, 32'h300, 32'h0, 0, 0, 32'h0, 4'h0, 0, 1'b0}, 99);
        ready = 1'b1;
        step();
        ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        rvalid = 1'b1;
        rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rstwait_inst", wb_inst, 32'h00000013);
        chk("rstwait_data", wb_data, 32'd0);
        chk("rstwait_wr", wb_wr, 1'b0);
        chk("rstwait_req", dmem_req, 1'b0);
        chk("rstwait_stall", stall, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("rstwait_after_data", wb_data, 32'd0);
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
